sram_like_data_ram: RTL and testbench

//   Data-side slave for the core's sram-like data port (data_req/addr_ok/data_ok).

---
 rtl/sram_like_pkg.sv | 39 +++
 rtl/sram_like_resp_pipe.sv | 31 +++
 rtl/sram_like_data_ram.sv | 125 ++++++++++++
 tb/tb_sram_like_data_ram.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like data RAM: access size encoding,
// response record, byte-enable decode and alignment check.
package sram_like_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} sram_size_e;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    function automatic logic [3:0] be_from_size(input sram_size_e size, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr;
            SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input sram_size_e size, input logic [1:0] addr);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_like_resp_pipe.sv
// Fixed-latency response delay line carrying {valid, err, rdata}; every stage
// is cleared by the asynchronous active-low reset so in-flight answers are dropped.
module sram_like_resp_pipe
    import sram_like_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t i_resp,
    output resp_t o_resp
);

    resp_t r_stage [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_resp;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_resp = r_stage[LATENCY-1];

endmodule

// File: rtl/sram_like_data_ram.sv
// Data-side sram-like slave: byte/half/word writes, full-word reads, fixed-latency
// in-order responses, bounded outstanding count. RANDOM_STALL_EN adds LFSR back-pressure.
module sram_like_data_ram
    import sram_like_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        misalign_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]           r_mem [2**ADDR_WIDTH];
    logic [CNT_W-1:0]      r_count;
    logic                  r_data_ok;
    logic [31:0]           r_rdata;
    logic                  r_misalign;

    logic                  w_stall;
    logic                  w_accept;
    logic                  w_mis;
    logic [3:0]            w_be;
    sram_size_e            w_size;
    logic [ADDR_WIDTH-1:0] w_idx;
    resp_t                 w_pipe_in;
    resp_t                 w_pipe_out;
    logic                  w_unused;

`ifdef RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    // Galois form, taps 16,14,13,11 -> feedback mask 16'hB400.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_size       = sram_size_e'(data_size);
    assign w_idx        = data_addr[ADDR_WIDTH+1:2];
    assign w_mis        = is_misaligned(w_size, data_addr[1:0]);
    assign w_be         = w_mis ? 4'b0000 : be_from_size(w_size, data_addr[1:0]);
    assign data_addr_ok = rst && (r_count < CNT_W'(MAX_OUTSTANDING)) && !w_stall;
    assign w_accept     = data_req && data_addr_ok;
    assign w_unused     = ^{data_addr[31:ADDR_WIDTH+2], w_pipe_out.err};

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (w_accept && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads sample the array on the accept edge, so earlier writes are visible.
    assign w_pipe_in.valid = w_accept;
    assign w_pipe_in.err   = w_mis;
    assign w_pipe_in.rdata = (w_accept && !data_wr && !w_mis) ? r_mem[w_idx] : 32'h0;

    sram_like_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_resp (w_pipe_in),
        .o_resp (w_pipe_out)
    );

    // The retire edge is the one that raises data_ok; a same-edge accept still
    // sees the old count through addr_ok.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_pipe_out.valid})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_ok  <= 1'b0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_data_ok <= w_pipe_out.valid;
            if (w_pipe_out.valid) begin
                r_rdata <= w_pipe_out.rdata;
            end
            if (w_accept && w_mis) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign data_data_ok = r_data_ok;
    assign data_rdata   = r_rdata;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_sram_like_data_ram.sv
// Self-checking bench for sram_like_data_ram: directed scenarios plus randomized
// traffic against a byte-level memory model and an in-order response scoreboard.
module tb_sram_like_data_ram;

    localparam int AW     = 14;
    localparam int LAT    = 2;
    localparam int MAXO   = 4;
    localparam int LAT_B  = 4;
    localparam int MAXO_B = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok, merr;
    logic [31:0] rdata;

    logic        b_req = 1'b0, b_wr = 1'b0;
    logic [1:0]  b_size = 2'd2;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
    logic        b_addr_ok, b_data_ok, b_merr;
    logic [31:0] b_rdata;

    sram_like_data_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr), .data_size(size),
        .data_addr(addr), .data_wdata(wdata), .data_addr_ok(addr_ok),
        .data_data_ok(data_ok), .data_rdata(rdata), .misalign_err(merr)
    );

    sram_like_data_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT_B), .MAX_OUTSTANDING(MAXO_B)) dut_b (
        .clk(clk), .rst(rst), .data_req(b_req), .data_wr(b_wr), .data_size(b_size),
        .data_addr(b_addr), .data_wdata(b_wdata), .data_addr_ok(b_addr_ok),
        .data_data_ok(b_data_ok), .data_rdata(b_rdata), .misalign_err(b_merr)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // reference model and scoreboard
    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] last_rdata = 32'h0;

    function automatic logic model_bad(input int sz, input logic [31:0] a);
        if (sz == 0) return 1'b0;
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b1;
    endfunction

    task automatic model_apply(input logic w, input int sz, input logic [31:0] a,
                               input logic [31:0] wd, output logic [31:0] rd);
        int unsigned idx;
        logic [31:0] cur;
        logic        sel;
        idx = (a >> 2) % (1 << AW);
        rd  = 32'h0;
        if (!model_bad(sz, a)) begin
            cur = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
            if (w) begin
                for (int lane = 0; lane < 4; lane++) begin
                    sel = (sz == 2) || (sz == 0 && lane == int'(a % 4)) ||
                          (sz == 1 && lane / 2 == int'(a % 4) / 2);
                    if (sel) cur[8*lane +: 8] = wd[8*lane +: 8];
                end
                model_mem[idx] = cur;
            end else begin
                rd = cur;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc && !data_ok) begin
                tests_run++;
                tests_failed++;
                $display("FAIL missing_data_ok: expected at cycle %0d, none by %0d", exp_cyc_q[0], cyc);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (data_ok) begin
                last_rdata = rdata;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_data_ok: cycle %0d rdata=%h", cyc, rdata);
                end else begin
                    if (rdata !== exp_q[0] || cyc != exp_cyc_q[0]) begin
                        tests_failed++;
                        $display("FAIL response: got rdata=%h at cycle %0d, want rdata=%h at cycle %0d",
                                 rdata, cyc, exp_q[0], exp_cyc_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic issue(input logic w, input int sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        int n;
        req = 1'b1; wr = w; size = sz[1:0]; addr = a; wdata = wd; n = 0;
        while (!addr_ok && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!addr_ok) begin
            tests_failed++;
            $display("FAIL accept_timeout: addr=%h addr_ok=%b after %0d cycles", a, addr_ok, n);
            req = 1'b0;
            return;
        end
        model_apply(w, sz, a, wd, rd);
        exp_q.push_back(rd);
        exp_cyc_q.push_back(cyc + 1 + LAT);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({addr_ok, data_ok, merr, rdata} !== 35'h0 || {b_addr_ok, b_data_ok, b_merr} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_outputs: addr_ok=%b data_ok=%b merr=%b rdata=%h, want all 0",
                     addr_ok, data_ok, merr, rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (addr_ok !== 1'b1 || b_addr_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr_ok_after_reset: got %b/%b want 1/1", addr_ok, b_addr_ok);
        end
    endtask

    task automatic test_word_rw();
        issue(1'b1, 2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2, 32'h10, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_read: got %h want DEADBEEF", last_rdata);
        end
    endtask

    task automatic test_byte_half();
        issue(1'b1, 0, 32'h11, 32'h0000AB00);
        issue(1'b0, 2, 32'h10, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'hDEADABEF) begin
            tests_failed++;
            $display("FAIL byte_write: got %h want DEADABEF", last_rdata);
        end
        issue(1'b1, 1, 32'h12, 32'h12340000);
        issue(1'b0, 2, 32'h10, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'h1234ABEF) begin
            tests_failed++;
            $display("FAIL half_write: got %h want 1234ABEF", last_rdata);
        end
    endtask

    task automatic test_misalign();
        tests_run++;
        if (merr !== 1'b0) begin
            tests_failed++;
            $display("FAIL merr_initial: got %b want 0", merr);
        end
        issue(1'b0, 1, 32'h13, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'h0 || merr !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_half: rdata=%h merr=%b, want 0 and 1", last_rdata, merr);
        end
        issue(1'b0, 2, 32'h10, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'h1234ABEF || merr !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_misalign: rdata=%h merr=%b, want 1234ABEF and 1", last_rdata, merr);
        end
    endtask

    task automatic test_alias();
        logic [31:0] a;
        a = 32'h10 | (32'h1 << (AW + 2));
        issue(1'b0, 2, a, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'h1234ABEF) begin
            tests_failed++;
            $display("FAIL alias_read: got %h want 1234ABEF", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) issue(1'b1, 2, 32'h100 + 4 * i, $urandom);
        start = cyc;
        for (int i = 0; i < 8; i++) issue(1'b0, 2, 32'h100 + 4 * i, 32'h0);
        tests_run++;
        if (cyc - start != 8) begin
            tests_failed++;
            $display("FAIL back_to_back_rate: 8 accepts took %0d cycles, want 8", cyc - start);
        end
        for (int i = 0; i < 200; i++) begin
            a = 32'h100 + $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 3) << (AW + 2));
            issue($urandom_range(0, 1) == 1, $urandom_range(0, 3), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
    endtask

    task automatic run_b(input logic w, input logic [31:0] words[6]);
        int acc, resp, n;
        logic took;
        logic [31:0] want;
        acc = 0; resp = 0; n = 0;
        b_wr = w; b_size = 2'd2; b_addr = 32'h40; b_wdata = words[0]; b_req = 1'b1;
        while (!(acc == 6 && resp == 6) && n < 300) begin
            if (b_data_ok) begin
                resp++;
                want = w ? 32'h0 : words[(resp - 1) % 6];
                tests_run++;
                if (resp > 6 || b_rdata !== want) begin
                    tests_failed++;
                    $display("FAIL b_response %0d: rdata=%h want %h", resp, b_rdata, want);
                end
            end
            tests_run++;
            if (b_addr_ok !== ((acc - resp) < MAXO_B)) begin
                tests_failed++;
                $display("FAIL b_addr_ok: got %b want %b (accepted %0d answered %0d)",
                         b_addr_ok, (acc - resp) < MAXO_B, acc, resp);
            end
            took = b_req && b_addr_ok;
            @(negedge clk);
            n++;
            if (took) begin
                acc++;
                if (acc < 6) begin
                    b_addr = 32'h40 + 4 * acc;
                    b_wdata = words[acc];
                end
            end
            b_req = (acc < 6);
        end
        repeat (8) begin
            if (b_data_ok) resp++;
            @(negedge clk);
        end
        tests_run++;
        if (acc != 6 || resp != 6) begin
            tests_failed++;
            $display("FAIL b_totals: accepts=%0d data_ok=%0d, want 6 and 6", acc, resp);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words[6];
        for (int i = 0; i < 6; i++) words[i] = $urandom ^ (32'h1 << i);
        run_b(1'b1, words);
        run_b(1'b0, words);
    endtask

    task automatic test_reset_inflight();
        issue(1'b1, 2, 32'h10, 32'hDEADBEEF);
        drain();
        issue(1'b0, 2, 32'h10, 32'h0);
        issue(1'b0, 2, 32'h10, 32'h0);
        rst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if (data_ok !== 1'b0 || addr_ok !== 1'b0 || merr !== 1'b0) begin
                tests_failed++;
                $display("FAIL in_reset: data_ok=%b addr_ok=%b merr=%b, want 0 0 0", data_ok, addr_ok, merr);
            end
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if (data_ok !== 1'b0 || addr_ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL after_reset: data_ok=%b addr_ok=%b, want 0 1", data_ok, addr_ok);
            end
        end
        issue(1'b0, 2, 32'h10, 32'h0);
        drain();
        tests_run++;
        if (last_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL mem_kept: got %h want DEADBEEF", last_rdata);
        end
    endtask

    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_misalign();
        test_alias();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
